// File: rtl/dl11_fifo_regs.sv
// rtl/dl11_fifo_regs.sv - DL11-style console register block with RX/TX byte FIFOs
module dl11_fifo_regs #(
    parameter logic [12:0] BASE_ADDR = 13'o17560,
    parameter logic [7:0]  VECTOR    = 8'o60,
    parameter int          RX_AW     = 4,
    parameter int          TX_AW     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] iopage_addr,
    input  logic [15:0] data_in,
    input  logic        iopage_rd,
    input  logic        iopage_wr,
    input  logic        iopage_byte_op,
    output logic [15:0] data_out,
    output logic        decode,
    output logic        interrupt,
    input  logic        interrupt_ack,
    output logic [7:0]  vector,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_ferr,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam logic [7:0]       TX_VECTOR = VECTOR + 8'd4;
    localparam logic [RX_AW:0]   RX_DEPTH  = 1 << RX_AW;
    localparam logic [TX_AW:0]   TX_DEPTH  = 1 << TX_AW;
    localparam logic [RX_AW-1:0] RX_ONE    = 1;
    localparam logic [TX_AW-1:0] TX_ONE    = 1;
    localparam logic [13:0]      BASE_LO   = {1'b0, BASE_ADDR};
    localparam logic [13:0]      BASE_HI   = {1'b0, BASE_ADDR} + 14'd7;

    logic [8:0]       rx_mem [0:(1<<RX_AW)-1];
    logic [RX_AW-1:0] rx_wptr, rx_rptr;
    logic [RX_AW:0]   rx_count;
    logic [7:0]       tx_mem [0:(1<<TX_AW)-1];
    logic [TX_AW-1:0] tx_wptr, tx_rptr;
    logic [TX_AW:0]   tx_count;

    logic       rie, tie, ovr, tx_req, tie_ready_q;
    logic [7:0] xbuf_last;

    logic [1:0]  sel;
    logic        even, wr_ok;
    logic        rcsr_wr, xcsr_wr, xbuf_wr;
    logic        rx_empty, rx_full, tx_empty, tx_full;
    logic        rx_pop, rx_push, tx_push, tx_pop;
    logic [8:0]  rx_head;
    logic        ferr_head, done, ready, rx_int;
    logic        tie_ready, tx_set, tx_clr;
    logic [15:0] reg_val;

    // BASE_ADDR is even, so the register index needs no borrow from bit 0
    assign decode  = ({1'b0, iopage_addr} >= BASE_LO) && ({1'b0, iopage_addr} <= BASE_HI);
    assign sel     = iopage_addr[2:1] - BASE_ADDR[2:1];
    assign even    = !iopage_byte_op || !iopage_addr[0];
    assign wr_ok   = iopage_wr && decode && even;
    assign rcsr_wr = wr_ok && (sel == 2'd0);
    assign xcsr_wr = wr_ok && (sel == 2'd2);
    assign xbuf_wr = wr_ok && (sel == 2'd3);

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_DEPTH);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_DEPTH);

    assign rx_pop  = iopage_rd && decode && (sel == 2'd1) && even && !rx_empty;
    assign rx_push = rx_valid && (!rx_full || rx_pop);
    assign tx_push = xbuf_wr && !tx_full;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[tx_rptr];
    assign tx_pop   = tx_valid && tx_ready;

    assign rx_head   = rx_mem[rx_rptr];
    assign ferr_head = rx_head[8] && !rx_empty;
    assign done      = !rx_empty;
    assign ready     = !tx_full;

    always_comb begin
        reg_val = 16'h0000;
        case (sel)
            2'd0: reg_val = {8'b0, done, rie, 6'b0};
            2'd1: if (!rx_empty)
                      reg_val = {ovr | ferr_head, ovr, ferr_head, 5'b0, rx_head[7:0]};
            2'd2: reg_val = {8'b0, ready, tie, 6'b0};
            2'd3: reg_val = {8'b0, xbuf_last};
            default: reg_val = 16'h0000;
        endcase
    end

    always_comb begin
        data_out = 16'h0000;
        if (iopage_rd && decode) begin
            if (iopage_byte_op)
                data_out = {8'b0, iopage_addr[0] ? reg_val[15:8] : reg_val[7:0]};
            else
                data_out = reg_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wptr] <= {rx_ferr, rx_data};
        if (tx_push)
            tx_mem[tx_wptr] <= data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + RX_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + RX_ONE;
            rx_count <= rx_count + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
            if (tx_push) tx_wptr <= tx_wptr + TX_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + TX_ONE;
            tx_count <= tx_count + {{TX_AW{1'b0}}, tx_push} - {{TX_AW{1'b0}}, tx_pop};
        end
    end

    // A pop clears ovr first; a dropped byte in the same cycle then sets it again
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr       <= 1'b0;
            rie       <= 1'b0;
            tie       <= 1'b0;
            xbuf_last <= 8'h00;
        end else begin
            if (rx_valid && !rx_push)
                ovr <= 1'b1;
            else if (rx_pop)
                ovr <= 1'b0;
            if (rcsr_wr) rie <= data_in[6];
            if (xcsr_wr) tie <= data_in[6];
            if (xbuf_wr) xbuf_last <= data_in[7:0];
        end
    end

    assign rx_int    = rie && done;
    assign tie_ready = tie && ready;
    assign tx_set    = tie_ready && !tie_ready_q;
    assign tx_clr    = (interrupt_ack && (vector == TX_VECTOR)) || xbuf_wr || !tie;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_req      <= 1'b0;
            tie_ready_q <= 1'b0;
        end else begin
            tie_ready_q <= tie_ready;
            if (tx_set)
                tx_req <= 1'b1;
            else if (tx_clr)
                tx_req <= 1'b0;
        end
    end

    assign interrupt = rx_int || tx_req;
    assign vector    = rx_int ? VECTOR : (tx_req ? TX_VECTOR : 8'h00);

endmodule

// File: tb/tb_dl11_fifo_regs.sv
// tb/tb_dl11_fifo_regs.sv - directed vector bench for dl11_fifo_regs
module tb_dl11_fifo_regs;

    localparam logic [12:0] B    = 13'o17560;
    localparam logic [12:0] RCSR = B;
    localparam logic [12:0] RBUF = B + 13'd2;
    localparam logic [12:0] XCSR = B + 13'd4;
    localparam logic [12:0] XBUF = B + 13'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] iopage_addr;
    logic [15:0] data_in;
    logic        iopage_rd, iopage_wr, iopage_byte_op;
    logic [15:0] data_out;
    logic        decode, interrupt, interrupt_ack;
    logic [7:0]  vector;
    logic        rx_valid, rx_ferr;
    logic [7:0]  rx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;

    int nvec = 0;
    int nerr = 0;

    dl11_fifo_regs dut (
        .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
        .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
        .data_out(data_out), .decode(decode), .interrupt(interrupt),
        .interrupt_ack(interrupt_ack), .vector(vector), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ferr(rx_ferr), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    typedef enum logic [3:0] {OP_IDLE, OP_WR, OP_RD, OP_RX, OP_INT, OP_TXH, OP_TXP, OP_ACK, OP_DEC} op_t;
    typedef struct {
        op_t         op;
        logic [12:0] addr;
        logic        bop;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(op_t op, logic [12:0] a, logic b, logic [15:0] d, logic [15:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.bop = b; v.data = d; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge, so the next rising edge sees them stable
    task automatic drive(input logic rd, input logic wr, input logic bop, input logic [12:0] a,
                         input logic [15:0] d, input logic rv, input logic [8:0] rxd,
                         input logic tr, input logic ack);
        @(negedge clk);
        iopage_rd = rd; iopage_wr = wr; iopage_byte_op = bop; iopage_addr = a;
        data_in = d; rx_valid = rv; rx_data = rxd[7:0]; rx_ferr = rxd[8];
        tx_ready = tr; interrupt_ack = ack;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 13'd0, 16'h0, 0, 9'h0, 0, 0);
    endtask

    task automatic wr(input logic [12:0] a, input logic [15:0] d);
        drive(0, 1, 0, a, d, 0, 9'h0, 0, 0);
    endtask

    task automatic rd_chk(input string name, input logic [12:0] a, input logic [15:0] exp);
        drive(1, 0, 0, a, 16'h0, 0, 9'h0, 0, 0);
        check(name, data_out, exp);
    endtask

    task automatic rx(input logic [8:0] d);
        drive(0, 0, 0, 13'd0, 16'h0, 1, d, 0, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] got[$];
        reset = 1'b1;
        iopage_rd = 0; iopage_wr = 0; iopage_byte_op = 0; iopage_addr = 0; data_in = 0;
        rx_valid = 0; rx_data = 0; rx_ferr = 0; tx_ready = 0; interrupt_ack = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // reset state and T1: transmit interrupt, ack, first byte
        tbl.push_back(mk(OP_RD,  RCSR, 0, 16'h0,    16'h0000));
        tbl.push_back(mk(OP_RD,  XCSR, 0, 16'h0,    16'h0080));
        tbl.push_back(mk(OP_INT, 0,    0, 16'h0,    16'h0000));
        tbl.push_back(mk(OP_TXH, 0,    0, 16'h0,    16'h0000));
        tbl.push_back(mk(OP_WR,  XCSR, 0, 16'o100,  16'h0));
        tbl.push_back(mk(OP_IDLE,0,    0, 16'h0,    16'h0));
        tbl.push_back(mk(OP_INT, 0,    0, 16'h0,    16'h0134));
        tbl.push_back(mk(OP_RD,  XCSR, 0, 16'h0,    16'h00C0));
        tbl.push_back(mk(OP_ACK, 0,    0, 16'h0,    16'h0));
        tbl.push_back(mk(OP_INT, 0,    0, 16'h0,    16'h0000));
        tbl.push_back(mk(OP_WR,  XBUF, 0, 16'h0041, 16'h0));
        tbl.push_back(mk(OP_TXH, 0,    0, 16'h0,    16'h0141));
        tbl.push_back(mk(OP_RD,  XBUF, 0, 16'h0,    16'h0041));
        tbl.push_back(mk(OP_TXP, 0,    0, 16'h0,    16'h0141));
        tbl.push_back(mk(OP_TXH, 0,    0, 16'h0,    16'h0000));
        tbl.push_back(mk(OP_WR,  XCSR, 0, 16'h0,    16'h0));
        // T3: three received bytes with receive interrupt
        tbl.push_back(mk(OP_WR,  RCSR, 0, 16'o100,  16'h0));
        tbl.push_back(mk(OP_RX,  0,    0, 16'h0001, 16'h0));
        tbl.push_back(mk(OP_RX,  0,    0, 16'h0002, 16'h0));
        tbl.push_back(mk(OP_RX,  0,    0, 16'h0003, 16'h0));
        tbl.push_back(mk(OP_INT, 0,    0, 16'h0,    16'h0130));
        tbl.push_back(mk(OP_ACK, 0,    0, 16'h0,    16'h0));
        tbl.push_back(mk(OP_INT, 0,    0, 16'h0,    16'h0130));
        tbl.push_back(mk(OP_RD,  RCSR, 0, 16'h0,    16'h00C0));
        tbl.push_back(mk(OP_RD,  RBUF, 0, 16'h0,    16'h0001));
        tbl.push_back(mk(OP_RD,  RBUF, 0, 16'h0,    16'h0002));
        tbl.push_back(mk(OP_RD,  RBUF, 0, 16'h0,    16'h0003));
        tbl.push_back(mk(OP_RD,  RCSR, 0, 16'h0,    16'h0040));
        tbl.push_back(mk(OP_INT, 0,    0, 16'h0,    16'h0000));
        tbl.push_back(mk(OP_RD,  RBUF, 0, 16'h0,    16'h0000));
        // byte reads of XCSR
        tbl.push_back(mk(OP_RD,  XCSR,        1, 16'h0, 16'h0080));
        tbl.push_back(mk(OP_RD,  XCSR + 13'd1, 1, 16'h0, 16'h0000));
        // T6: framing error, odd byte read does not pop
        tbl.push_back(mk(OP_RX,  0,    0, 16'h0155, 16'h0));
        tbl.push_back(mk(OP_RD,  RBUF + 13'd1, 1, 16'h0, 16'o240));
        tbl.push_back(mk(OP_RD,  RBUF, 0, 16'h0,    16'o120125));
        tbl.push_back(mk(OP_RD,  RCSR, 0, 16'h0,    16'h0040));
        // odd-byte CSR write ignored, word write applies
        tbl.push_back(mk(OP_WR,  RCSR + 13'd1, 1, 16'h0000, 16'h0));
        tbl.push_back(mk(OP_RD,  RCSR, 0, 16'h0,    16'h0040));
        tbl.push_back(mk(OP_WR,  RCSR, 0, 16'h0000, 16'h0));
        tbl.push_back(mk(OP_RD,  RCSR, 0, 16'h0,    16'h0000));
        // address decode edges and out-of-range read
        tbl.push_back(mk(OP_DEC, B - 13'd1, 0, 16'h0, 16'h0000));
        tbl.push_back(mk(OP_DEC, B,         0, 16'h0, 16'h0001));
        tbl.push_back(mk(OP_DEC, B + 13'd7, 0, 16'h0, 16'h0001));
        tbl.push_back(mk(OP_DEC, B + 13'd8, 0, 16'h0, 16'h0000));
        tbl.push_back(mk(OP_RD,  B + 13'd8, 0, 16'h0, 16'h0000));

        foreach (tbl[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            case (tbl[i].op)
                OP_WR:  drive(0, 1, tbl[i].bop, tbl[i].addr, tbl[i].data, 0, 9'h0, 0, 0);
                OP_RD:  begin
                            drive(1, 0, tbl[i].bop, tbl[i].addr, 16'h0, 0, 9'h0, 0, 0);
                            check(nm, data_out, tbl[i].exp);
                        end
                OP_RX:  rx(tbl[i].data[8:0]);
                OP_INT: begin idle(); check(nm, {7'b0, interrupt, vector}, tbl[i].exp); end
                OP_TXH: begin idle(); check(nm, {7'b0, tx_valid, tx_data}, tbl[i].exp); end
                OP_TXP: begin
                            drive(0, 0, 0, 13'd0, 16'h0, 0, 9'h0, 1, 0);
                            check(nm, {7'b0, tx_valid, tx_data}, tbl[i].exp);
                        end
                OP_ACK: drive(0, 0, 0, 13'd0, 16'h0, 0, 9'h0, 0, 1);
                OP_DEC: begin
                            drive(0, 0, 0, tbl[i].addr, 16'h0, 0, 9'h0, 0, 0);
                            check(nm, {15'b0, decode}, tbl[i].exp);
                        end
                default: idle();
            endcase
        end

        // T2: 17 writes into a 16-deep TX FIFO with the UART stalled
        for (int i = 0; i < 17; i++) begin
            wr(XBUF, 16'(8'h10 + i));
            if (i == 14) rd_chk("t2_ready15", XCSR, 16'h0080);
            if (i == 15) rd_chk("t2_full16", XCSR, 16'h0000);
        end
        for (int c = 0; c < 40; c++) begin
            drive(0, 0, 0, 13'd0, 16'h0, 0, 9'h0, 1, 0);
            if (tx_valid) got.push_back(tx_data);
        end
        check("t2_count", 16'(got.size()), 16'd16);
        for (int i = 0; i < got.size() && i < 16; i++)
            check($sformatf("t2_byte%0d", i), {8'b0, got[i]}, 16'(8'h10 + i));

        // T4: overflow sets ovr, next pop clears it, dropped byte never appears
        for (int i = 0; i < 16; i++) rx(9'(8'h80 + i));
        rx(9'h0EE);
        rd_chk("t4_ovr", RBUF, 16'o140000 | 16'h0080);
        for (int i = 1; i < 16; i++)
            rd_chk($sformatf("t4_rd%0d", i), RBUF, 16'(8'h80 + i));
        rd_chk("t4_empty", RCSR, 16'h0000);

        // T5: push into a full FIFO in the same cycle as a pop
        for (int i = 0; i < 16; i++) rx(9'(8'h20 + i));
        drive(1, 0, 0, RBUF, 16'h0, 1, 9'h077, 0, 0);
        check("t5_pop", data_out, 16'h0020);
        for (int i = 1; i < 16; i++)
            rd_chk($sformatf("t5_rd%0d", i), RBUF, 16'(8'h20 + i));
        rd_chk("t5_last", RBUF, 16'h0077);
        rd_chk("t5_empty", RCSR, 16'h0000);

        // reset with both FIFOs holding data
        rx(9'h011);
        wr(XBUF, 16'h0022);
        idle();
        check("rst_pre_tx", {15'b0, tx_valid}, 16'h0001);
        rd_chk("rst_pre_rx", RCSR, 16'h0080);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_tx", {7'b0, tx_valid, tx_data} & 16'h0100, 16'h0000);
        rd_chk("rst_rcsr", RCSR, 16'h0000);
        rd_chk("rst_rbuf", RBUF, 16'h0000);
        rd_chk("rst_xcsr", XCSR, 16'h0080);
        check("rst_int", {7'b0, interrupt, vector}, 16'h0000);

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
